// File: rtl/idex_pipe_reg.sv
// ---------------------------------------------------------------------------
// idex_pipe_reg
//   Parametrised ID/EX pipeline register for the 5-stage MIPS core.
//   Carries the control bundle and instruction fields from ID into EX. It adds
//   a per-slot valid bit, a downstream hold, a branch-flush bubble, load-use
//   hazard detection with automatic bubble insertion, and saturating
//   bubble/stall counters.
//
// Ports
//   CLK, RESET        clock (rising edge), asynchronous active-high reset
//   id_*              instruction fields presented by the ID stage
//   stall_in          EX/MEM cannot accept: hold every EX register
//   flush             taken branch/jump: turn the EX slot into a bubble
//   hazard_stall      combinational: freeze PC and IF/ID this cycle
//   ex_*              registered instruction fields for the EX stage
//   bubble_cnt        bubbles inserted (flush + load-use), saturating
//   stall_cnt         cycles held by stall_in, saturating
// ---------------------------------------------------------------------------
module idex_pipe_reg #(
  parameter int CTRL_W      = 11,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int MEMREAD_BIT = 3,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [5:0]        id_opcode,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [5:0]        id_funct,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              stall_in,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [5:0]        ex_opcode,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_shamt,
  output logic [5:0]        ex_funct,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  logic lu_s;
  logic bubble_ev_s;
  logic stall_ev_s;

  // Load-use detection: a load in EX whose destination (nonzero) is read in ID.
  always_comb begin
    lu_s = 1'b0;
    if (ex_valid && ex_ctrl[MEMREAD_BIT] && id_valid && (ex_rt != {REG_W{1'b0}})) begin
      lu_s = (ex_rt == id_rs) || (ex_rt == id_rt);
    end else begin
      lu_s = 1'b0;
    end
  end

  // flush and stall_in both pre-empt the hazard: the ID instruction is not
  // going anywhere this cycle, so detection is redone once they clear.
  assign hazard_stall = lu_s & ~flush & ~stall_in;

  // A flush always bubbles; a load-use bubbles only when not held. Counting
  // as one event keeps flush+lu from double-counting.
  assign bubble_ev_s = flush | (lu_s & ~stall_in);
  assign stall_ev_s  = stall_in & ~flush;

  // EX slot registers: priority flush > hold > load-use bubble > capture.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= {CTRL_W{1'b0}};
      ex_opcode  <= 6'd0;
      ex_rs      <= {REG_W{1'b0}};
      ex_rt      <= {REG_W{1'b0}};
      ex_rd      <= {REG_W{1'b0}};
      ex_rs_data <= {DATA_W{1'b0}};
      ex_rt_data <= {DATA_W{1'b0}};
      ex_imm     <= {DATA_W{1'b0}};
      ex_shamt   <= 5'd0;
      ex_funct   <= 6'd0;
      ex_pc4     <= {DATA_W{1'b0}};
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= {CTRL_W{1'b0}};
    end else if (stall_in) begin
      ex_valid <= ex_valid;
      ex_ctrl  <= ex_ctrl;
    end else if (lu_s) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= {CTRL_W{1'b0}};
    end else begin
      ex_valid   <= id_valid;
      // An invalid slot must never carry live control bits.
      ex_ctrl    <= id_valid ? id_ctrl : {CTRL_W{1'b0}};
      ex_opcode  <= id_opcode;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_shamt   <= id_shamt;
      ex_funct   <= id_funct;
      ex_pc4     <= id_pc4;
    end
  end

  // Saturating performance counters, cleared only by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bubble_cnt <= {CNT_W{1'b0}};
      stall_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (bubble_ev_s) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end else begin
        bubble_cnt <= bubble_cnt;
      end
      if (stall_ev_s) begin
        stall_cnt <= sat_inc(stall_cnt);
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

endmodule

// File: tb/tb_idex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_idex_pipe_reg
//   Scoreboard bench for idex_pipe_reg (CNT_W = 4 so saturation is reachable).
//   Stimulus drives one cycle's inputs just after the rising edge and pushes
//   the hand-computed expectation for that cycle; the monitor pops and
//   compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_idex_pipe_reg;

  logic        CLK;
  logic        RESET;
  logic        id_valid;
  logic [10:0] id_ctrl;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic        stall_in, flush;
  logic        hazard_stall, ex_valid;
  logic [10:0] ex_ctrl;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [3:0]  bubble_cnt, stall_cnt;

  idex_pipe_reg #(.CTRL_W(11), .DATA_W(32), .REG_W(5), .MEMREAD_BIT(3), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_funct(id_funct), .id_pc4(id_pc4),
    .stall_in(stall_in), .flush(flush), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_opcode(ex_opcode),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_pc4(ex_pc4),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    int          cyc;
    logic        v;
    logic [10:0] ctrl;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [3:0]  bub;
    logic [3:0]  stl;
    logic        haz;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks = checks + 1;
    if (act !== exp_v) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp_v);
    end
  endtask

  // Monitor: compare every sampled output against the front of the scoreboard.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      exp_t s;
      s = sb.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL stale_entry: cycle %0d never sampled (now %0d)", s.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("ex_valid",     {31'd0, ex_valid},     {31'd0, e.v});
      chk("ex_ctrl",      {21'd0, ex_ctrl},      {21'd0, e.ctrl});
      chk("ex_pc4",       ex_pc4,                e.pc4);
      chk("ex_rs",        {27'd0, ex_rs},        {27'd0, e.rs});
      chk("bubble_cnt",   {28'd0, bubble_cnt},   {28'd0, e.bub});
      chk("stall_cnt",    {28'd0, stall_cnt},    {28'd0, e.stl});
      chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, e.haz});
    end
  end

  task automatic drive(input logic v, input logic [10:0] ctrl, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [31:0] pc4,
                       input logic st, input logic fl);
    id_valid = v;  id_ctrl = ctrl; id_rs = rs; id_rt = rt; id_pc4 = pc4;
    stall_in = st; flush = fl;
  endtask

  // One cycle: inputs for this cycle plus the state/hazard expected during it.
  task automatic step(input logic v, input logic [10:0] ctrl, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [31:0] pc4,
                      input logic st, input logic fl,
                      input logic ev, input logic [10:0] ectrl, input logic [31:0] epc4,
                      input logic [4:0] ers, input logic [3:0] ebub, input logic [3:0] estl,
                      input logic ehaz);
    exp_t e;
    @(posedge CLK);
    #1;
    drive(v, ctrl, rs, rt, pc4, st, fl);
    e.cyc = cyc; e.v = ev; e.ctrl = ectrl; e.pc4 = epc4; e.rs = ers;
    e.bub = ebub; e.stl = estl; e.haz = ehaz;
    sb.push_back(e);
  endtask

  initial begin
    int b;
    RESET      = 1'b1;
    id_opcode  = 6'h23;  id_rd = 5'd1;  id_rs_data = 32'h1111_1111;
    id_rt_data = 32'h2222_2222;  id_imm = 32'hFFFF_FFFC;
    id_shamt   = 5'd0;   id_funct = 6'h20;
    drive(1'b0, 11'h000, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    //    v  ctrl    rs     rt     pc4     st fl | ev ctrl    pc4     rs     bub   stl   haz
    step(1, 11'h155, 5'd1,  5'd2,  32'h10, 0, 0,   0, 11'h000, 32'h00, 5'd0,  4'd0, 4'd0, 0);
    step(1, 11'h008, 5'd3,  5'd8,  32'h14, 0, 0,   1, 11'h155, 32'h10, 5'd1,  4'd0, 4'd0, 0);
    step(1, 11'h001, 5'd8,  5'd9,  32'h18, 0, 0,   1, 11'h008, 32'h14, 5'd3,  4'd0, 4'd0, 1);
    step(1, 11'h001, 5'd8,  5'd9,  32'h18, 0, 0,   0, 11'h000, 32'h14, 5'd3,  4'd1, 4'd0, 0);
    step(1, 11'h008, 5'd5,  5'd0,  32'h1C, 0, 0,   1, 11'h001, 32'h18, 5'd8,  4'd1, 4'd0, 0);
    step(1, 11'h002, 5'd0,  5'd0,  32'h20, 0, 0,   1, 11'h008, 32'h1C, 5'd5,  4'd1, 4'd0, 0);
    step(1, 11'h004, 5'd6,  5'd7,  32'h24, 1, 0,   1, 11'h002, 32'h20, 5'd0,  4'd1, 4'd0, 0);
    step(1, 11'h004, 5'd6,  5'd7,  32'h24, 1, 0,   1, 11'h002, 32'h20, 5'd0,  4'd1, 4'd1, 0);
    step(1, 11'h004, 5'd6,  5'd7,  32'h24, 1, 0,   1, 11'h002, 32'h20, 5'd0,  4'd1, 4'd2, 0);
    step(1, 11'h004, 5'd6,  5'd7,  32'h24, 1, 1,   1, 11'h002, 32'h20, 5'd0,  4'd1, 4'd3, 0);
    step(1, 11'h008, 5'd1,  5'd10, 32'h28, 0, 0,   0, 11'h000, 32'h20, 5'd0,  4'd2, 4'd3, 0);
    step(1, 11'h001, 5'd2,  5'd10, 32'h2C, 0, 1,   1, 11'h008, 32'h28, 5'd1,  4'd2, 4'd3, 0);
    step(1, 11'h008, 5'd4,  5'd11, 32'h30, 0, 0,   0, 11'h000, 32'h28, 5'd1,  4'd3, 4'd3, 0);
    step(1, 11'h001, 5'd11, 5'd0,  32'h34, 1, 0,   1, 11'h008, 32'h30, 5'd4,  4'd3, 4'd3, 0);
    step(1, 11'h001, 5'd11, 5'd0,  32'h34, 0, 0,   1, 11'h008, 32'h30, 5'd4,  4'd3, 4'd4, 1);
    step(0, 11'h3FF, 5'd31, 5'd1,  32'h38, 0, 0,   0, 11'h000, 32'h30, 5'd4,  4'd4, 4'd4, 0);
    step(1, 11'h008, 5'd2,  5'd12, 32'h3C, 0, 0,   0, 11'h000, 32'h38, 5'd31, 4'd4, 4'd4, 0);
    step(1, 11'h001, 5'd3,  5'd12, 32'h40, 0, 0,   1, 11'h008, 32'h3C, 5'd2,  4'd4, 4'd4, 1);
    step(1, 11'h001, 5'd3,  5'd12, 32'h40, 0, 0,   0, 11'h000, 32'h3C, 5'd2,  4'd5, 4'd4, 0);
    step(0, 11'h000, 5'd0,  5'd0,  32'h00, 0, 0,   1, 11'h001, 32'h40, 5'd3,  4'd5, 4'd4, 0);
    // Twenty consecutive flushes: bubble_cnt must stick at 15.
    for (int i = 0; i < 20; i++) begin
      b = (5 + i > 15) ? 15 : 5 + i;
      step(0, 11'h000, 5'd0, 5'd0, 32'h00, 0, 1, 0, 11'h000, 32'h00, 5'd0, b[3:0], 4'd4, 0);
    end
    step(1, 11'h155, 5'd7,  5'd0,  32'h44, 0, 0,   0, 11'h000, 32'h00, 5'd0,  4'd15, 4'd4, 0);
    step(0, 11'h000, 5'd0,  5'd0,  32'h00, 1, 0,   1, 11'h155, 32'h44, 5'd7,  4'd15, 4'd4, 0);
    step(0, 11'h000, 5'd0,  5'd0,  32'h00, 1, 0,   1, 11'h155, 32'h44, 5'd7,  4'd15, 4'd5, 0);

    // Asynchronous reset pulse in the middle of a held cycle.
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    drive(1'b1, 11'h0A2, 5'd9, 5'd0, 32'h48, 1'b0, 1'b0);
    #1;
    chk("async_rst_valid",  {31'd0, ex_valid},     32'd0);
    chk("async_rst_ctrl",   {21'd0, ex_ctrl},      32'd0);
    chk("async_rst_pc4",    ex_pc4,                32'd0);
    chk("async_rst_rs",     {27'd0, ex_rs},        32'd0);
    chk("async_rst_bubble", {28'd0, bubble_cnt},   32'd0);
    chk("async_rst_stall",  {28'd0, stall_cnt},    32'd0);
    chk("async_rst_hazard", {31'd0, hazard_stall}, 32'd0);
    #1 RESET = 1'b0;
    step(0, 11'h000, 5'd0,  5'd0,  32'h00, 0, 0,   1, 11'h0A2, 32'h48, 5'd9,  4'd0, 4'd0, 0);

    // Let the monitor drain the scoreboard, bounded.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge CLK);
    @(negedge CLK);
    #1;
    if (sb.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
